// File: rtl/bayer_rgb_luma_reader_pkg.sv
// Shared types and constants for the Bayer RGB-to-luma reader stage.
// Latency: n/a (package only).
// Backpressure: n/a. Holds image geometry, luma coefficients, FSM state type,
// the pixel record carried through the output FIFO and the luma helper.
package bayer_rgb_luma_reader_pkg;

  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;

  // BT.601-style integer weights scaled by 256, plus half-LSB rounding.
  localparam logic [15:0] LUMA_C_R = 16'd77;
  localparam logic [15:0] LUMA_C_G = 16'd150;
  localparam logic [15:0] LUMA_C_B = 16'd29;
  localparam logic [15:0] LUMA_RND = 16'd128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        y;
  } pix_t;

  // Weights sum to 256, so the worst case is 255*256+128 = 65408: fits in
  // 16 bits and the top byte never exceeds 255.
  function automatic logic [7:0] luma(input logic [7:0] r,
                                      input logic [7:0] g,
                                      input logic [7:0] b);
    logic [15:0] acc;
    acc = LUMA_C_R * {8'd0, r} + LUMA_C_G * {8'd0, g} + LUMA_C_B * {8'd0, b} + LUMA_RND;
    return acc[15:8];
  endfunction

endpackage

// File: rtl/bayer_rgb_luma_reader_if.sv
// Bundle of the reader's frame control, memory read and pixel stream signals.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready on the pixel stream. master = reader side,
// slave = the surrounding top level / consumer / memories.
interface bayer_rgb_luma_reader_if;
  import bayer_rgb_luma_reader_pkg::*;

  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rdata_r;
  logic [7:0]        rdata_g;
  logic [7:0]        rdata_b;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport master (
    input  start, rdata_r, rdata_g, rdata_b, out_ready,
    output rd_en, rd_addr, out_valid, out_data, out_addr, busy, done
  );

  modport slave (
    output start, rdata_r, rdata_g, rdata_b, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, out_addr, busy, done
  );

endinterface

// File: rtl/bayer_rgb_luma_reader_pix_skid_fifo.sv
// pix_skid_fifo: 2-entry synchronous FIFO for streaming pixel stages.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full unless popping in the same
// cycle; push and pop together are legal at any occupancy.
// Ports: clk, reset (sync, active-high), push_i/push_dat_i, pop_i,
// pop_dat_o (head), count_o, full_o, empty_o.
module pix_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // When full and popping, wr_ptr equals rd_ptr: the new entry lands in the
  // slot being vacated, which is exactly what a same-cycle push/pop needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);

endmodule

// File: rtl/bayer_rgb_luma_reader.sv
// bayer_rgb_luma_reader: after start, raster-scans the R/G/B memories and streams 8-bit luma.
// Latency: start -> first rd_en 1 cycle, first out_valid 3 cycles, then 1 pixel/clk.
// Backpressure: reads are throttled so the 2-entry FIFO never overflows; head held while !out_ready.
// Ports: clk, reset (sync, active-high); bus (master): start, rd_en/rd_addr, rdata_r/g/b,
// out_valid/out_ready/out_data/out_addr, busy, done.
module bayer_rgb_luma_reader #(
  parameter int IMG_W         = bayer_rgb_luma_reader_pkg::IMG_W,
  parameter bit INTERIOR_ONLY = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  bayer_rgb_luma_reader_if.master bus
);
  import bayer_rgb_luma_reader_pkg::*;

  localparam int COL_W      = $clog2(IMG_W);
  localparam int FIRST_COL  = INTERIOR_ONLY ? 1 : 0;
  localparam int LAST_COL_I = INTERIOR_ONLY ? IMG_W - 2 : IMG_W - 1;

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(LAST_COL_I);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_COL * IMG_W + FIRST_COL);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAST_COL_I * IMG_W + LAST_COL_I);
  // Step from the last scanned column of a row to the first of the next row.
  localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(IMG_W - LAST_COL_I + FIRST_COL);

  state_t            state_q;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_addr_q;

  pix_t              push_pix;
  pix_t              head_pix;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              rd_en;
  logic              drained;
  logic [2:0]        occ;

  assign pop = !fifo_empty && bus.out_ready;

  // Entries that still need a FIFO slot: stored + landing this cycle, minus
  // the one leaving on this cycle's handshake. A read issued now lands next
  // cycle, so keeping this below 2 means returned data always has room even
  // if out_ready then stays low. Counting the departing slot is what allows
  // one read per clock when out_ready is held high.
  assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en = (state_q == RUN) && (occ < 3'd2);

  // Last pixel leaves on this cycle's handshake (or already left) with
  // nothing in flight, so done can appear on the very next cycle.
  assign drained = !inflight_q && (fifo_empty || (!fifo_full && pop));

  always_comb begin
    scan_addr_d = scan_addr_q + ADDR_W'(1);
    if (scan_addr_q[COL_W-1:0] == LAST_COL) scan_addr_d = scan_addr_q + WRAP_STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      scan_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RUN;
            scan_addr_q <= START_ADDR;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (rd_en) begin
            if (scan_addr_q == LAST_ADDR) state_q <= DRAIN;
            else                          scan_addr_q <= scan_addr_d;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory data arrives the cycle after rd_en; remember which address it is.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) inflight_addr_q <= scan_addr_q;
    end
  end

  assign push_pix = '{addr: inflight_addr_q, y: luma(bus.rdata_r, bus.rdata_g, bus.rdata_b)};

  pix_skid_fifo #(.WIDTH($bits(pix_t))) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_dat_i (push_pix),
    .pop_i      (pop),
    .pop_dat_o  (head_pix),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = scan_addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_pix.y;
  assign bus.out_addr  = head_pix.addr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bayer_rgb_luma_reader.sv
// Bench for bayer_rgb_luma_reader: interior-only and full-frame instances,
// behavioural memories, a frame-level reference model and one compare process.
module tb_bayer_rgb_luma_reader;

  logic clk;
  logic reset;

  bayer_rgb_luma_reader_if ia ();
  bayer_rgb_luma_reader_if ib ();

  bayer_rgb_luma_reader #(.INTERIOR_ONLY(1'b1)) dut_int (.clk(clk), .reset(reset), .bus(ia));
  bayer_rgb_luma_reader #(.INTERIOR_ONLY(1'b0)) dut_full (.clk(clk), .reset(reset), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int mem_mode = 0;

  // Per-instance model / observation state (index 0 = interior, 1 = full frame).
  bit armed [2];
  bit done_seen [2];
  bit exp_done [2];
  bit prev_stall [2];
  int prev_a [2];
  int prev_y [2];
  int hs_idx [2];
  int rd_idx [2];
  int cyc [2];
  int first_rd_cyc [2];
  int first_vld_cyc [2];
  int done_cyc [2];
  int done_cnt [2];
  int first_addr [2];
  int first_data [2];
  int last_addr [2];
  int last_data [2];
  int addr_at_128;
  int sp_y [4];

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nframe(input int d);
    return (d == 0) ? 126 * 126 : 128 * 128;
  endfunction

  // idx-th pixel of the raster scan.
  function automatic int exp_addr(input int d, input int idx);
    if (d == 0) return (1 + idx / 126) * 128 + 1 + idx % 126;
    return idx;
  endfunction

  function automatic logic [23:0] mem_rgb(input int a);
    logic [7:0] v;
    v = 8'(a);
    if (mem_mode == 0) return {v, v, v};
    case (a)
      129: return 24'hFFFFFF;
      130: return 24'hFF0000;
      131: return 24'h00FF00;
      132: return 24'h0000FF;
      default: ;
    endcase
    return {8'(a * 13), 8'(a * 7 + 91), 8'(a ^ (a >> 5))};
  endfunction

  function automatic int ref_y(input int a);
    logic [23:0] c;
    c = mem_rgb(a);
    return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]) + 128) / 256;
  endfunction

  // Memories: the read address seen during a cycle produces data for the next.
  bit rq [2];
  int ra [2];
  always @(negedge clk) begin
    rq[0] = ia.rd_en; ra[0] = int'(ia.rd_addr);
    rq[1] = ib.rd_en; ra[1] = int'(ib.rd_addr);
  end
  always @(posedge clk) begin
    #1;
    if (rq[0]) {ia.rdata_r, ia.rdata_g, ia.rdata_b} = mem_rgb(ra[0]);
    else       {ia.rdata_r, ia.rdata_g, ia.rdata_b} = 24'($urandom);
    if (rq[1]) {ib.rdata_r, ib.rdata_g, ib.rdata_b} = mem_rgb(ra[1]);
    else       {ib.rdata_r, ib.rdata_g, ib.rdata_b} = 24'($urandom);
  end

  task automatic mon(input int d, input bit vld, input bit rdy, input int oa, input int oy,
                     input bit re, input int rda, input bit dn, input bit bsy);
    bit hs;
    hs = vld && rdy;
    if (armed[d]) begin
      if (re) begin
        if (first_rd_cyc[d] < 0) first_rd_cyc[d] = cyc[d];
        chk("rd_within_frame", int'(rd_idx[d] < nframe(d)), 1);
        chk("rd_addr", rda, exp_addr(d, rd_idx[d]));
        chk("rd_outstanding_lt2", int'((rd_idx[d] - hs_idx[d] - int'(hs)) < 2), 1);
        rd_idx[d]++;
      end
      if (vld && first_vld_cyc[d] < 0) first_vld_cyc[d] = cyc[d];
      if (prev_stall[d]) begin
        chk("hold_valid", int'(vld), 1);
        chk("hold_addr", oa, prev_a[d]);
        chk("hold_data", oy, prev_y[d]);
      end
      chk("done", int'(dn), int'(exp_done[d]));
      chk("busy", int'(bsy), int'(cyc[d] >= 1 && !done_seen[d] && !exp_done[d]));
      if (dn) begin
        done_seen[d] = 1'b1;
        done_cyc[d]  = cyc[d];
        done_cnt[d]++;
      end
      exp_done[d] = 1'b0;
      if (hs) begin
        if (hs_idx[d] < nframe(d)) begin
          chk("out_addr", oa, exp_addr(d, hs_idx[d]));
          chk("out_data", oy, ref_y(exp_addr(d, hs_idx[d])));
          if (hs_idx[d] == 0) begin first_addr[d] = oa; first_data[d] = oy; end
          if (hs_idx[d] == nframe(d) - 1) begin last_addr[d] = oa; last_data[d] = oy; end
          if (d == 1 && hs_idx[d] == 128) addr_at_128 = oa;
          if (d == 0 && oa >= 129 && oa <= 132) sp_y[oa - 129] = oy;
          hs_idx[d]++;
          if (hs_idx[d] == nframe(d)) exp_done[d] = 1'b1;
        end else begin
          chk("extra_handshake", hs_idx[d] + 1, nframe(d));
        end
      end
      prev_stall[d] = vld && !rdy;
      prev_a[d]     = oa;
      prev_y[d]     = oy;
      cyc[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.out_valid, ia.out_ready, int'(ia.out_addr), int'(ia.out_data),
        ia.rd_en, int'(ia.rd_addr), ia.done, ia.busy);
    mon(1, ib.out_valid, ib.out_ready, int'(ib.out_addr), int'(ib.out_data),
        ib.rd_en, int'(ib.rd_addr), ib.done, ib.busy);
  end

  task automatic arm_frame(input int d);
    hs_idx[d] = 0; rd_idx[d] = 0; cyc[d] = 0;
    first_rd_cyc[d] = -1; first_vld_cyc[d] = -1; done_cyc[d] = -1; done_cnt[d] = 0;
    first_addr[d] = -1; first_data[d] = -1; last_addr[d] = -1; last_data[d] = -1;
    done_seen[d] = 1'b0; exp_done[d] = 1'b0; prev_stall[d] = 1'b0;
    armed[d] = 1'b1;
  endtask

  task automatic drive(input int d, input bit st, input bit rdy);
    if (d == 0) begin ia.start = st; ia.out_ready = rdy; end
    else        begin ib.start = st; ib.out_ready = rdy; end
  endtask

  task automatic chk_reset_vals(input int d);
    if (d == 0) begin
      chk("rst_rd_en", int'(ia.rd_en), 0);       chk("rst_rd_addr", int'(ia.rd_addr), 0);
      chk("rst_out_valid", int'(ia.out_valid), 0); chk("rst_out_data", int'(ia.out_data), 0);
      chk("rst_out_addr", int'(ia.out_addr), 0); chk("rst_busy", int'(ia.busy), 0);
      chk("rst_done", int'(ia.done), 0);
    end else begin
      chk("rst_rd_en", int'(ib.rd_en), 0);       chk("rst_rd_addr", int'(ib.rd_addr), 0);
      chk("rst_out_valid", int'(ib.out_valid), 0); chk("rst_out_data", int'(ib.out_data), 0);
      chk("rst_out_addr", int'(ib.out_addr), 0); chk("rst_busy", int'(ib.busy), 0);
      chk("rst_done", int'(ib.done), 0);
    end
  endtask

  // Start a frame and run it to done; start is re-pulsed twice mid-frame.
  task automatic run_frame(input int d, input bit rnd, input int budget);
    int n;
    @(posedge clk); #1;
    arm_frame(d);
    drive(d, 1'b1, 1'b1);
    n = 0;
    while (!done_seen[d] && n < budget) begin
      @(posedge clk); #1;
      n++;
      drive(d, (n == 40 || n == 3000), rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    drive(d, 1'b0, 1'b1);
    chk("frame_finished", int'(done_seen[d]), 1);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) armed[d] = 1'b0;
    for (int i = 0; i < 4; i++) sp_y[i] = -1;
    addr_at_128 = -1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 1'b0;

    // Frame A: both geometries, out_ready held high.
    mem_mode = 0;
    fork
      run_frame(0, 1'b0, 40000);
      run_frame(1, 1'b0, 40000);
    join
    chk("A_int_first_addr", first_addr[0], 129);
    chk("A_int_first_data", first_data[0], 129);
    chk("A_int_last_addr", last_addr[0], 16254);
    chk("A_int_last_data", last_data[0], 126);
    chk("A_int_handshakes", hs_idx[0], 15876);
    chk("A_int_done_pulses", done_cnt[0], 1);
    chk("A_int_first_rd_cyc", first_rd_cyc[0], 1);
    chk("A_int_first_vld_cyc", first_vld_cyc[0], 3);
    chk("A_int_done_cyc", done_cyc[0], 15876 + 3);
    chk("A_full_first_addr", first_addr[1], 0);
    chk("A_full_first_data", first_data[1], 0);
    chk("A_full_last_addr", last_addr[1], 16383);
    chk("A_full_last_data", last_data[1], 255);
    chk("A_full_handshakes", hs_idx[1], 16384);
    chk("A_full_wrap_addr", addr_at_128, 128);
    chk("A_full_done_pulses", done_cnt[1], 1);
    chk("A_full_done_cyc", done_cyc[1], 16384 + 3);

    // Frame B: reset after 500 accepted pixels aborts the frame.
    @(posedge clk); #1;
    arm_frame(0);
    drive(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1);
    n = 0;
    while (hs_idx[0] < 500 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("B_reached_pixel_500", hs_idx[0], 500);
    armed[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("B_no_done_after_abort", int'(ia.done), 0);
      chk("B_idle_after_abort", int'(ia.out_valid || ia.busy || ia.rd_en), 0);
    end

    // Frame C: fresh scan, random backpressure, colour test pixels at 129..132.
    mem_mode = 1;
    run_frame(0, 1'b1, 60000);
    chk("C_first_addr", first_addr[0], 129);
    chk("C_white_y", sp_y[0], 255);
    chk("C_red_y", sp_y[1], 77);
    chk("C_green_y", sp_y[2], 149);
    chk("C_blue_y", sp_y[3], 29);
    chk("C_last_addr", last_addr[0], 16254);
    chk("C_handshakes", hs_idx[0], 15876);
    chk("C_done_pulses", done_cnt[0], 1);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
